// File: rtl/div_sequencer.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU issued from the EX stage.
// Latency: done_o 34 cycles after accept; 1 cycle for divide-by-zero and signed overflow.
// Backpressure: stall_o holds the pipeline while accepting, iterating and sign-fixing; drops in DONE.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q;
  logic [4:0]       cnt_q;
  logic [1:0]       op_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;

  logic             signed_op;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] special_res;

  logic [WIDTH:0]   part_rem;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quot_nxt;

  logic             neg_quot;
  logic             neg_rem;
  logic [WIDTH-1:0] fixed_res;

  assign busy_o  = (state_q != IDLE);
  // Reset dominates so a held reset never freezes the pipeline.
  assign stall_o = ~rst_i & (((state_q == IDLE) & start_i & ~flush_i) |
                             (state_q == CALC) | (state_q == FIX));

  // Operand decode at accept time: magnitudes and the two early-out cases.
  always_comb begin
    signed_op   = ~op_i[0];
    abs_a       = (signed_op & dividend_i[WIDTH-1]) ? (ZERO - dividend_i) : dividend_i;
    abs_b       = (signed_op & divisor_i[WIDTH-1])  ? (ZERO - divisor_i)  : divisor_i;
    div_zero    = (divisor_i == ZERO);
    overflow    = signed_op & (dividend_i == MIN_NEG) & (divisor_i == ALL_ONES);
    special_res = div_zero ? (op_i[1] ? dividend_i : ALL_ONES)
                           : (op_i[1] ? ZERO : MIN_NEG);
  end

  // One restoring step: shift the next dividend bit into a 33-bit partial remainder.
  // When the trial subtract fits, the true difference is below 2^32, so 32-bit math is exact.
  always_comb begin
    part_rem = {rem_q, quot_q[WIDTH-1]};
    fits     = (part_rem >= {1'b0, dvs_q});
    rem_nxt  = fits ? (part_rem[WIDTH-1:0] - dvs_q) : part_rem[WIDTH-1:0];
    quot_nxt = {quot_q[WIDTH-2:0], fits};
  end

  // Sign correction of the unsigned result; quotient sign from both operands, remainder from dividend.
  always_comb begin
    neg_quot = ~op_q[0] & (sign_a_q ^ sign_b_q);
    neg_rem  = ~op_q[0] & sign_a_q;
    if (op_q[1]) fixed_res = neg_rem  ? (ZERO - rem_q)  : rem_q;
    else         fixed_res = neg_quot ? (ZERO - quot_q) : quot_q;
  end

  // Sequencer FSM with registered result and done pulse; flush abandons without touching result_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_o <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && !flush_i) begin
            op_q     <= op_i;
            sign_a_q <= dividend_i[WIDTH-1];
            sign_b_q <= divisor_i[WIDTH-1];
            quot_q   <= abs_a;
            rem_q    <= ZERO;
            dvs_q    <= abs_b;
            cnt_q    <= '0;
            if (div_zero || overflow) begin
              result_o <= special_res;
              done_o   <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            quot_q <= quot_nxt;
            rem_q  <= rem_nxt;
            cnt_q  <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= FIX;
          end
        end
        FIX: begin
          cnt_q <= '0;
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            result_o <= fixed_res;
            done_o   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; only 32 is supported.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 start_i  input  1  EX stage holds a DIV/DIVU/REM/REMU instruction; held high until done_o.
REQ-005 op_i  input  2  00 div, 01 divu, 10 rem, 11 remu; sampled with start_i.
REQ-006 dividend_i  input  32  rs1 value; sampled with start_i.
REQ-007 divisor_i  input  32  rs2 value; sampled with start_i.
REQ-008 flush_i  input  1  pipeline flush (branch/jump/interrupt); aborts the operation.
REQ-009 busy_o  output  1  high whenever state != IDLE.
REQ-010 stall_o  output  1  combinational pipeline hold request.
REQ-011 done_o  output  1  one-cycle pulse; result_o valid.
REQ-012 result_o  output  32  quotient or remainder; registered.

Function
REQ-013 FSM states: IDLE, CALC, FIX, DONE; 5-bit iteration counter.
REQ-014 IDLE: if start_i=1 and flush_i=0, latch op, the sign flags and the absolute operand values.
REQ-015 IDLE, normal operands: next state is CALC with counter=0.
REQ-016 IDLE, divisor==0 or signed overflow: next state is DONE, with result_o loaded directly.
REQ-017 CALC: one restoring shift-subtract step per cycle; 32 steps; after counter==31, next state is FIX.
REQ-018 FIX: negate the quotient if the operand signs differ (signed ops only).
REQ-019 FIX: negate the remainder if the dividend is negative (signed ops only).
REQ-020 FIX: load result_o and go to DONE.
REQ-021 DONE: done_o=1 for exactly one cycle, then IDLE unconditionally; start_i in DONE is ignored.
REQ-022 Latency, normal: done_o high in the 34th cycle after the accepting edge (1 accept + 32 CALC + 1 FIX).
REQ-023 Latency, special case: done_o high in the cycle immediately after the accepting edge.
REQ-024 stall_o = (IDLE & start_i & ~flush_i) | CALC | FIX; stall_o=0 in DONE so the pipeline consumes result_o.
REQ-025 Divide by zero: div/divu give 0xFFFFFFFF; rem/remu give the dividend unchanged.
REQ-026 Overflow (div/rem only, 0x80000000 / 0xFFFFFFFF): div gives 0x80000000; rem gives 0.
REQ-027 Signed magnitudes use 32-bit two's complement; abs(0x80000000)=0x80000000 treated as unsigned; the partial remainder is 33 bits.
REQ-028 flush_i in any state: next state IDLE, counter cleared, done_o not asserted, result_o holds its previous value.
REQ-029 flush_i in DONE: done_o still pulses that cycle; next state IDLE.
REQ-030 Operand changes on the inputs after acceptance have no effect on the result.

Reset
REQ-031 rst_i=1 at an edge: state IDLE, counter 0, internal registers 0, result_o 0, done_o 0, busy_o 0; overrides flush_i and start_i.
REQ-032 With rst_i held high, stall_o is 0 regardless of start_i.
REQ-033 Reset mid-CALC: the operation is abandoned, with no done_o pulse afterwards.

Verification
REQ-034 divu 100/7 -> stall_o high for 34 cycles, done_o pulse in cycle 34, result_o=14; remu same operands -> 2.
REQ-035 div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF; div 7/-2 -> 0xFFFFFFFD; rem 7/-2 -> 1.
REQ-036 div 5/0 -> 0xFFFFFFFF, done_o one cycle after accept; rem 5/0 -> 5; divu 0x80000000/0 -> 0xFFFFFFFF.
REQ-037 div 0x80000000/0xFFFFFFFF -> 0x80000000; rem -> 0; divu same operands -> 0 after the full 34 cycles.
REQ-038 flush_i at CALC cycle 10 -> busy_o=0 next cycle, no done_o, result_o unchanged; a following divu 9/3 -> 3 at normal latency.
REQ-039 rst_i asserted at CALC cycle 20 -> all outputs 0 next cycle; no done_o until the next accepted start.
